// File: rtl/mem_pkg.sv
// Shared types and constants for the memory slot arbiter.
// owner_t names the requester that owns a 4-tick bus cycle.
// PHASE_LAST is the clk8 phase on which a bus cycle completes.
// At that same edge the next owner is decided.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VIDEO,
    SOUND,
    DSK_INT,
    DSK_EXT,
    CPU
  } owner_t;

  localparam logic [1:0] PHASE_LAST     = 2'd3;
  localparam int         DEFAULT_ADDR_W = 22;

endpackage

// File: rtl/slot_priority.sv
// Purely combinational priority table for the memory slot arbiter.
// It is kept separate from the sequencing logic so the table can be unit-tested.
//
// Ports:
//   video_req    video needs the next bus cycle
//   sound_pend   a sound word is pending for this line
//   dsk_req_int  internal-drive byte fetch request
//   dsk_req_ext  external-drive byte fetch request
//   cpu_req      CPU RAM/ROM access pending
//   cpu_starved  CPU has been denied often enough to beat sound and disk
//   rr           disk round-robin pointer (0 prefers the internal drive)
//   next_owner   owner for the next bus cycle
module slot_priority
  import mem_pkg::*;
(
  input  logic   video_req,
  input  logic   sound_pend,
  input  logic   dsk_req_int,
  input  logic   dsk_req_ext,
  input  logic   cpu_req,
  input  logic   cpu_starved,
  input  logic   rr,
  output owner_t next_owner
);

  // Video is never overridden; a starved CPU jumps ahead of sound and disk.
  // The round-robin pointer only matters when both drives ask at once.
  always_comb begin
    next_owner = IDLE;
    if (video_req)
      next_owner = VIDEO;
    else if (cpu_req && cpu_starved)
      next_owner = CPU;
    else if (sound_pend)
      next_owner = SOUND;
    else if (dsk_req_int && dsk_req_ext)
      next_owner = rr ? DSK_EXT : DSK_INT;
    else if (dsk_req_int)
      next_owner = DSK_INT;
    else if (dsk_req_ext)
      next_owner = DSK_EXT;
    else if (cpu_req)
      next_owner = CPU;
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot scheduler for the shared 16-bit RAM/ROM bus.
// The scheduler splits clk8 into 4-tick bus cycles.
// Each bus cycle is granted to exactly one of:
//   video, sound, internal floppy, external floppy or CPU.
//
// Ports:
//   clk32 / _systemReset        system clock, async active-low reset
//   clk8_en_p                   clk8 rising-phase enable
//   *_req / *_addr              requester levels/pulses and fetch addresses
//   cpu_rw                      1 = read, 0 = write
//   mem_addr / mem_we           registered bus address and write enable
//   videoBusControl             video owns the current cycle
//   cpuBusControl               CPU owns the current cycle
//   memoryLatch                 data-valid strobe at the end of an owned cycle
//   loadSound, dskReadAckInt,
//   dskReadAckExt, cpu_done     per-requester completion pulses
//   sound_miss                  a sound request was dropped
module mem_slot_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int CPU_STARVE = 3
) (
  input  logic              clk32,
  input  logic              _systemReset,
  input  logic              clk8_en_p,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic              sound_req,
  input  logic [ADDR_W-1:0] sound_addr,
  input  logic              dsk_req_int,
  input  logic [ADDR_W-1:0] dsk_addr_int,
  input  logic              dsk_req_ext,
  input  logic [ADDR_W-1:0] dsk_addr_ext,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              videoBusControl,
  output logic              cpuBusControl,
  output logic              memoryLatch,
  output logic              loadSound,
  output logic              dskReadAckInt,
  output logic              dskReadAckExt,
  output logic              cpu_done,
  output logic              sound_miss
);

  // The starve counter is 2 bits wide, so the threshold is held at the same width.
  localparam logic [1:0] STARVE_LIM = 2'(CPU_STARVE);

  logic [1:0]        phase;
  owner_t            owner;
  owner_t            next_owner;
  logic              rr;
  logic              sound_pend;
  logic [1:0]        starve_cnt;
  logic              decide;
  logic              complete;
  logic              cpu_starved;
  logic              sound_grant;
  logic [ADDR_W-1:0] next_addr;

  // The last clk8 tick of a cycle completes the current owner.
  // The same tick decides the next owner.
  assign decide      = clk8_en_p && (phase == PHASE_LAST);
  assign complete    = decide && (owner != IDLE);
  assign cpu_starved = (starve_cnt >= STARVE_LIM);
  assign sound_grant = decide && (next_owner == SOUND);

  slot_priority u_slot_priority (
    .video_req   (video_req),
    .sound_pend  (sound_pend),
    .dsk_req_int (dsk_req_int),
    .dsk_req_ext (dsk_req_ext),
    .cpu_req     (cpu_req),
    .cpu_starved (cpu_starved),
    .rr          (rr),
    .next_owner  (next_owner)
  );

  // An IDLE cycle leaves the bus address where it was.
  always_comb begin
    next_addr = mem_addr;
    case (next_owner)
      VIDEO:   next_addr = video_addr;
      SOUND:   next_addr = sound_addr;
      DSK_INT: next_addr = dsk_addr_int;
      DSK_EXT: next_addr = dsk_addr_ext;
      CPU:     next_addr = cpu_addr;
      default: next_addr = mem_addr;
    endcase
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset)
      phase <= 2'd0;
    else if (clk8_en_p)
      phase <= phase + 2'd1;
  end

  // Everything the bus sees for a cycle is captured at the decision edge.
  // It then stays stable for all four ticks of that cycle.
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      owner           <= IDLE;
      videoBusControl <= 1'b0;
      cpuBusControl   <= 1'b0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      rr              <= 1'b0;
      starve_cnt      <= 2'd0;
    end else if (decide) begin
      owner           <= next_owner;
      videoBusControl <= (next_owner == VIDEO);
      cpuBusControl   <= (next_owner == CPU);
      mem_addr        <= next_addr;
      mem_we          <= (next_owner == CPU) && !cpu_rw;
      if (next_owner == DSK_INT || next_owner == DSK_EXT)
        rr <= ~rr;
      if (!cpu_req || next_owner == CPU)
        starve_cnt <= 2'd0;
      else if (starve_cnt != 2'd3)
        starve_cnt <= starve_cnt + 2'd1;
    end
  end

  // A new request wins over a same-edge grant, so a back-to-back word is not lost.
  // A request arriving while one is already queued is dropped and reported.
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset)
      sound_pend <= 1'b0;
    else if (sound_req)
      sound_pend <= 1'b1;
    else if (sound_grant)
      sound_pend <= 1'b0;
  end

  assign sound_miss    = sound_req && sound_pend && !sound_grant;

  assign memoryLatch   = complete;
  assign loadSound     = complete && (owner == SOUND);
  assign dskReadAckInt = complete && (owner == DSK_INT);
  assign dskReadAckExt = complete && (owner == DSK_EXT);
  assign cpu_done      = complete && (owner == CPU);

endmodule

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
- Time-slot scheduler for the shared 16-bit RAM/ROM bus. Requesters: video, sound, internal floppy, external floppy and CPU.
- Divides clk8 into 4-tick bus cycles and grants each cycle to exactly one owner.
- Drives the memory address/write-enable mux, the busControl flags, the memoryLatch strobe and the per-requester ack/done pulses consumed by the data controller.

Parameters:
- ADDR_W, 22: memory word-address width.
- CPU_STARVE, 3: consecutive denied CPU bus cycles after which the CPU overrides sound and disk.

Ports:
- clk32 input 1: 32.5 MHz system clock.
- _systemReset input 1: asynchronous active-low reset.
- clk8_en_p input 1: clk8 rising-phase enable.
- video_req input 1: level; video needs the next bus cycle.
- video_addr input ADDR_W: video fetch address.
- sound_req input 1: one-clk32 pulse; one sound word needed this line.
- sound_addr input ADDR_W: sound fetch address.
- dsk_req_int input 1: level; internal-drive byte fetch.
- dsk_addr_int input ADDR_W: internal-drive address.
- dsk_req_ext input 1: level; external-drive byte fetch.
- dsk_addr_ext input ADDR_W: external-drive address.
- cpu_req input 1: level; CPU memory access pending (AS asserted, RAM/ROM decode).
- cpu_rw input 1: 1 = read, 0 = write.
- cpu_addr input ADDR_W: CPU address.
- mem_addr output ADDR_W: registered bus address.
- mem_we output 1: write enable; CPU write slots only.
- videoBusControl output 1: video owns the current cycle.
- cpuBusControl output 1: CPU owns the current cycle.
- memoryLatch output 1: one-clk32 data-valid strobe.
- loadSound output 1: one-clk32 pulse; sound word on the bus.
- dskReadAckInt output 1: one-clk32 pulse; internal-drive data valid.
- dskReadAckExt output 1: one-clk32 pulse; external-drive data valid.
- cpu_done output 1: one-clk32 pulse; CPU access complete (DTACK source).
- sound_miss output 1: one-clk32 pulse; sound_req dropped.

Behaviour:
- Phase counter, 2 bits:
  - Advances only on clk8_en_p, wrapping 3->0.
  - A bus cycle is phases 0..3, i.e. 4 clk8 ticks.
- Owner register (shared enum): IDLE, VIDEO, SOUND, DSK_INT, DSK_EXT, CPU. Decided on the clk32 edge where clk8_en_p=1 and phase==3, so it is valid for the whole next cycle.
- Priority at decision time:
  1. VIDEO if video_req.
  2. CPU if cpu_req and starve_cnt >= CPU_STARVE.
  3. SOUND if sound_pend.
  4. Disk, when one or both disk requests are present: the one pointed to by rr; rr=0 prefers DSK_INT. rr toggles after each disk grant; a lone requester wins regardless of rr.
  5. CPU if cpu_req.
  6. Otherwise IDLE.
- Address and write enable are registered at that same decision edge:
  - mem_addr takes the selected requester's address; it holds its previous value when the owner is IDLE.
  - mem_we = (owner==CPU && !cpu_rw). It is held for the full cycle.
- Bus-control flags:
  - videoBusControl = (owner==VIDEO).
  - cpuBusControl = (owner==CPU).
  - Both are registered and change only at bus-cycle boundaries.
- Completion edge is clk8_en_p with phase==3 (the same edge as the next decision). When owner != IDLE, exactly one clk32 pulse is asserted:
  - memoryLatch.
  - plus the matching completion pulse: loadSound, dskReadAckInt, dskReadAckExt or cpu_done. VIDEO gets memoryLatch only.
  - Pulses are combinational from registered owner/phase ANDed with clk8_en_p. Latency from grant to pulse is 4 clk8 ticks.
- sound_pend:
  - Set on sound_req; cleared when SOUND is granted.
  - A pulse in the same clk32 as the grant leaves it set (set wins).
  - sound_req while already pending and not being granted: sound_miss pulses and the request is dropped.
- Disk requests are levels.
  - A requester must hold req until its ack; dropping req early forfeits the slot, but an already-granted cycle still completes and acks.
- starve_cnt, 2-bit saturating:
  - Incremented at each decision where cpu_req=1 and CPU is not granted.
  - Cleared on CPU grant or when cpu_req=0.
  - Video is never overridden.
- Asynchronous reset, and reset mid-cycle:
  - Values: phase=0, owner=IDLE, rr=0, sound_pend=0, starve_cnt=0, mem_addr=0, mem_we=0.
  - All pulses and busControl flags go to 0 immediately.
  - No ack is issued for a cycle interrupted by reset.

Decomposition:
- Shared package mem_pkg holds:
  - owner_t enum (IDLE, VIDEO, SOUND, DSK_INT, DSK_EXT, CPU).
  - PHASE_LAST=2'd3.
  - Default ADDR_W.
- One sub-module, slot_priority: purely combinational. Takes the request vector, rr and the starve flag; returns the next owner_t. This keeps the priority table unit-testable.

Test Plan:
- Reset, then clk8_en_p every 4th clk32 with no requests: owner IDLE, memoryLatch never asserts, mem_we=0, all acks 0.
- cpu_req=1, cpu_rw=0, cpu_addr=22'h012345: next cycle cpuBusControl=1, mem_addr=22'h012345, mem_we=1; cpu_done and memoryLatch pulse once 4 clk8 ticks later.
- video_req held high with cpu_req=1: VIDEO wins every cycle, starve_cnt saturates at 3, cpu_done never fires. Drop video_req: CPU is granted on the next decision.
- dsk_req_int and dsk_req_ext both high for 4 cycles: owners alternate INT, EXT, INT, EXT; one ack pulse each per grant; mem_addr tracks the respective address.
- sound_req pulse, then a second pulse before the grant: sound_miss pulses once, exactly one loadSound follows. A pulse coinciding with the grant edge keeps sound_pend=1 and a second loadSound occurs.
- cpu_req plus dsk_req_int held, CPU denied 3 times by SOUND/disk: the 4th decision grants CPU. Separately, assert _systemReset low at phase 2 of a DSK_INT cycle: no dskReadAckInt is issued and owner=IDLE after release.
